// File: rtl/acc_seq_if.sv
// acc_seq_if
//   Groups the descriptor handshake, the latched descriptor view and the
//   address stream of acc_seq into one bundle.
//   master : controller/consumer side (drives descriptors, accdone, addr_ready)
//   slave  : acc_seq side (drives cfg_ready, *A registers, address stream, status)
//   Parameters: ADDR_W address width, SIZE_W size-field width.
interface acc_seq_if #(
  parameter int ADDR_W = 6,
  parameter int SIZE_W = 6
);
  logic              accdone;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [ADDR_W-1:0] startaddr;
  logic [SIZE_W-1:0] datasize;
  logic              accbypass;
  logic              accbypassA;
  logic [ADDR_W-1:0] startaddrA;
  logic [SIZE_W-1:0] datasizeA;
  logic [ADDR_W-1:0] addr;
  logic              addr_valid;
  logic              addr_ready;
  logic              last;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    output accdone, cfg_valid, startaddr, datasize, accbypass, addr_ready,
    input  cfg_ready, accbypassA, startaddrA, datasizeA,
    input  addr, addr_valid, last, busy, done, err
  );

  modport slave (
    input  accdone, cfg_valid, startaddr, datasize, accbypass, addr_ready,
    output cfg_ready, accbypassA, startaddrA, datasizeA,
    output addr, addr_valid, last, busy, done, err
  );
endinterface

// File: rtl/acc_seq.sv
// acc_seq
//   Accepts a transfer descriptor (start address, size, bypass flag), keeps a
//   registered copy for the accelerator datapath, inserts HOLD settle cycles
//   for bypass descriptors and then emits the address sequence, wrapping at
//   MEM_DEPTH. accdone aborts any activity synchronously.
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous active-low reset
//   bus   - acc_seq_if.slave: descriptor handshake, latched descriptor,
//           address stream (addr/addr_valid/addr_ready/last), busy/done/err
// Optional feature:
//   ACC_SEQ_BACKTOBACK_EN - accept the next descriptor on the final beat of a
//   transfer, removing the IDLE bubble between descriptors.
module acc_seq #(
  parameter int ADDR_W    = 6,
  parameter int SIZE_W    = 6,
  parameter int MEM_DEPTH = 64,
  parameter int HOLD      = 3
) (
  input logic      clk,
  input logic      reset,
  acc_seq_if.slave bus
);

  localparam int CNT_W = (HOLD < 1) ? 1 : $clog2(HOLD + 1);
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(MEM_DEPTH);

  typedef enum logic [1:0] {IDLE, QUAL, RUN} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [SIZE_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              byp_q, byp_d;
  logic [ADDR_W-1:0] start_q, start_d;
  logic [SIZE_W-1:0] size_q, size_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              err_pend_q, err_pend_d;

  logic              run_w, last_w, addr_hs, accept, start_oob;
  logic [ADDR_W:0]   addr_p1;
  logic [ADDR_W-1:0] addr_inc;

  assign run_w   = (state_q == RUN);
  assign last_w  = run_w && (rem_q == SIZE_W'(1));
  assign addr_hs = run_w && bus.addr_ready;

  // Increment in one extra bit so MEM_DEPTH == 2**ADDR_W wraps correctly.
  assign addr_p1  = {1'b0, addr_q} + 1'b1;
  assign addr_inc = (addr_p1 == DEPTH_L) ? '0 : addr_p1[ADDR_W-1:0];

  assign start_oob = ({1'b0, bus.startaddr} >= DEPTH_L);

`ifdef ACC_SEQ_BACKTOBACK_EN
  assign bus.cfg_ready = ((state_q == IDLE) || (last_w && bus.addr_ready)) && !bus.accdone;
`else
  assign bus.cfg_ready = (state_q == IDLE) && !bus.accdone;
`endif

  assign accept = bus.cfg_valid && bus.cfg_ready;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    cnt_d      = cnt_q;
    byp_d      = byp_q;
    start_d    = start_q;
    size_d     = size_q;
    done_d     = 1'b0;
    err_d      = err_pend_q;
    err_pend_d = 1'b0;

    if (bus.accdone) begin
      state_d = IDLE;
      byp_d   = 1'b0;
      cnt_d   = '0;
      err_d   = 1'b0;
    end else begin
      case (state_q)
        QUAL: begin
          if (cnt_q == CNT_W'(HOLD - 1)) state_d = RUN;
          else                           cnt_d   = cnt_q + 1'b1;
        end
        RUN: begin
          if (addr_hs) begin
            addr_d = addr_inc;
            rem_d  = rem_q - 1'b1;
            if (last_w) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end
        end
        default: ;
      endcase

      // A new descriptor overrides the transfer-completion next state.
      if (accept) begin
        if (start_oob) begin
          // done and err must not share a cycle; a drop on the final beat
          // reports one cycle later.
          if (done_d) err_pend_d = 1'b1;
          else        err_d      = 1'b1;
        end else begin
          start_d = bus.startaddr;
          size_d  = bus.datasize;
          byp_d   = bus.accbypass;
          addr_d  = bus.startaddr;
          rem_d   = bus.datasize;
          if (bus.datasize == '0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else if (bus.accbypass && (HOLD > 0)) begin
            state_d = QUAL;
            cnt_d   = '0;
          end else begin
            state_d = RUN;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      rem_q      <= '0;
      cnt_q      <= '0;
      byp_q      <= 1'b0;
      start_q    <= '0;
      size_q     <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      cnt_q      <= cnt_d;
      byp_q      <= byp_d;
      start_q    <= start_d;
      size_q     <= size_d;
      done_q     <= done_d;
      err_q      <= err_d;
      err_pend_q <= err_pend_d;
    end
  end

  assign bus.addr       = addr_q;
  assign bus.addr_valid = run_w;
  assign bus.last       = last_w;
  assign bus.busy       = (state_q != IDLE);
  assign bus.done       = done_q;
  assign bus.err        = err_q;
  assign bus.accbypassA = byp_q;
  assign bus.startaddrA = start_q;
  assign bus.datasizeA  = size_q;

endmodule

// File: tb/tb_acc_seq.sv
// tb_acc_seq
//   Self-checking bench for acc_seq. Expected addresses come from a list
//   built as (start + i) % DEPTH; expected timing comes from the descriptor
//   latency rules (settle HOLD cycles for bypass, one address per ready cycle).
//   Inputs change on the falling edge, outputs are sampled on the falling edge.
module tb_acc_seq;

  localparam int ADDR_W = 7;
  localparam int SIZE_W = 6;
  localparam int DEPTH  = 64;
  localparam int HOLD   = 3;

  logic clk;
  logic reset;

  int total;
  int bad;

  // Reference copy of the latched descriptor.
  int exp_start_a;
  int exp_size_a;
  bit exp_byp_a;

  bit pat [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

  acc_seq_if #(.ADDR_W(ADDR_W), .SIZE_W(SIZE_W)) bus ();

  acc_seq #(
    .ADDR_W   (ADDR_W),
    .SIZE_W   (SIZE_W),
    .MEM_DEPTH(DEPTH),
    .HOLD     (HOLD)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic check_a_regs(input string tag);
    total++;
    if ({bus.startaddrA, bus.datasizeA, bus.accbypassA} !==
        {ADDR_W'(exp_start_a), SIZE_W'(exp_size_a), exp_byp_a}) begin
      bad++;
      $display("FAIL %s: A regs got start=%0d size=%0d byp=%0d want start=%0d size=%0d byp=%0d",
               tag, bus.startaddrA, bus.datasizeA, bus.accbypassA, exp_start_a, exp_size_a, exp_byp_a);
    end
  endtask

  // One descriptor end to end. mode: 0 ready always, 1 random ready, 2 pattern 1,0,0,1,1.
  task automatic run_desc(input int start, input int size, input bit byp, input int mode);
    int q[$];
    int lat, idx, k, p;
    bit rdy, exp_valid;
    for (int i = 0; i < size; i++) q.push_back((start + i) % DEPTH);
    lat = (byp && HOLD > 0) ? HOLD : 0;
    $display("desc start=%0d size=%0d byp=%0d mode=%0d", start, size, byp, mode);

    @(negedge clk);
    bus.cfg_valid  = 1'b1;
    bus.startaddr  = ADDR_W'(start);
    bus.datasize   = SIZE_W'(size);
    bus.accbypass  = byp;
    bus.addr_ready = 1'b1;
    #1;
    total++;
    if (bus.cfg_ready !== 1'b1) begin
      bad++;
      $display("FAIL cfg_ready_idle: got %b want 1", bus.cfg_ready);
    end
    @(negedge clk);
    bus.cfg_valid = 1'b0;

    if (start >= DEPTH) begin
      total++;
      if ({bus.err, bus.done, bus.busy, bus.addr_valid} !== 4'b1000) begin
        bad++;
        $display("FAIL drop_pulse: err/done/busy/valid got %b want 1000",
                 {bus.err, bus.done, bus.busy, bus.addr_valid});
      end
      check_a_regs("drop_a_unchanged");
      @(negedge clk);
      total++;
      if (bus.err !== 1'b0) begin
        bad++;
        $display("FAIL drop_err_width: got %b want 0", bus.err);
      end
      return;
    end

    exp_start_a = start;
    exp_size_a  = size;
    exp_byp_a   = byp;
    check_a_regs("accept_a_regs");

    if (size == 0) begin
      total++;
      if ({bus.done, bus.err, bus.busy, bus.addr_valid} !== 4'b1000) begin
        bad++;
        $display("FAIL zero_size: done/err/busy/valid got %b want 1000",
                 {bus.done, bus.err, bus.busy, bus.addr_valid});
      end
      @(negedge clk);
      total++;
      if ({bus.done, bus.addr_valid} !== 2'b00) begin
        bad++;
        $display("FAIL zero_size_after: done/valid got %b want 00", {bus.done, bus.addr_valid});
      end
      return;
    end

    idx = 0;
    p   = 0;
    k   = 0;
    while (idx < size && k < 300) begin
      exp_valid = (k >= lat);
      total++;
      if ({bus.addr_valid, bus.busy, bus.done, bus.err} !== {exp_valid, 1'b1, 1'b0, 1'b0}) begin
        bad++;
        $display("FAIL stream_status k=%0d: valid/busy/done/err got %b want %b",
                 k, {bus.addr_valid, bus.busy, bus.done, bus.err}, {exp_valid, 3'b100});
      end
      if (exp_valid) begin
        total++;
        if ({bus.addr, bus.last} !== {ADDR_W'(q[idx]), (idx == size - 1)}) begin
          bad++;
          $display("FAIL stream_addr beat=%0d: addr=%0d last=%b want addr=%0d last=%b",
                   idx, bus.addr, bus.last, q[idx], (idx == size - 1));
        end
      end
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = 1'($urandom_range(0, 1));
        default: rdy = pat[p % 5];
      endcase
      if (exp_valid) p++;
      bus.addr_ready = rdy;
      if (exp_valid && rdy) idx++;
      @(negedge clk);
      k++;
    end
    if (idx < size) begin
      total++;
      bad++;
      $display("FAIL stream_timeout: got %0d beats want %0d", idx, size);
    end
    total++;
    if ({bus.done, bus.err, bus.busy, bus.addr_valid} !== 4'b1000) begin
      bad++;
      $display("FAIL done_pulse: done/err/busy/valid got %b want 1000",
               {bus.done, bus.err, bus.busy, bus.addr_valid});
    end
    @(negedge clk);
    total++;
    if (bus.done !== 1'b0) begin
      bad++;
      $display("FAIL done_width: got %b want 0", bus.done);
    end
  endtask

  task automatic test_reset();
    reset          = 1'b0;
    bus.accdone    = 1'b0;
    bus.cfg_valid  = 1'b0;
    bus.startaddr  = '0;
    bus.datasize   = '0;
    bus.accbypass  = 1'b0;
    bus.addr_ready = 1'b0;
    exp_start_a    = 0;
    exp_size_a     = 0;
    exp_byp_a      = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({bus.addr, bus.addr_valid, bus.last, bus.busy, bus.done, bus.err} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: addr=%0d valid=%b last=%b busy=%b done=%b err=%b want all 0",
               bus.addr, bus.addr_valid, bus.last, bus.busy, bus.done, bus.err);
    end
    check_a_regs("reset_a_regs");
    total++;
    if (bus.cfg_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_cfg_ready: got %b want 1", bus.cfg_ready);
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    run_desc(5, 4, 1'b0, 0);
    run_desc(62, 4, 1'b0, 0);
    run_desc(0, 2, 1'b1, 0);
  endtask

  task automatic test_backpressure();
    run_desc(20, 3, 1'b0, 2);
    run_desc(60, 7, 1'b1, 2);
  endtask

  task automatic test_edges();
    run_desc(9, 0, 1'b0, 0);
    run_desc(64, 3, 1'b1, 0);
    run_desc(127, 5, 1'b0, 0);
    run_desc(63, 1, 1'b1, 0);
  endtask

  task automatic test_accdone();
    int beats;
    $display("desc start=30 size=6 byp=1 abort after 2 beats");
    @(negedge clk);
    bus.cfg_valid = 1'b1;
    bus.startaddr = ADDR_W'(30);
    bus.datasize  = SIZE_W'(6);
    bus.accbypass = 1'b1;
    bus.addr_ready = 1'b1;
    @(negedge clk);
    bus.cfg_valid = 1'b0;
    exp_start_a = 30;
    exp_size_a  = 6;
    exp_byp_a   = 1'b1;
    beats = 0;
    for (int k = 0; k < 50 && beats < 2; k++) begin
      if (bus.addr_valid === 1'b1) beats++;
      if (beats < 2) @(negedge clk);
    end
    // Two handshakes are done after the edge following the second valid cycle.
    @(negedge clk);
    bus.accdone = 1'b1;
    @(negedge clk);
    total++;
    if ({bus.addr_valid, bus.last, bus.busy, bus.done, bus.cfg_ready} !== 5'b00000) begin
      bad++;
      $display("FAIL abort_state: valid/last/busy/done/cfg_ready got %b want 00000",
               {bus.addr_valid, bus.last, bus.busy, bus.done, bus.cfg_ready});
    end
    exp_byp_a = 1'b0;
    check_a_regs("abort_a_regs");
    bus.accdone = 1'b0;
    #1;
    total++;
    if (bus.cfg_ready !== 1'b1) begin
      bad++;
      $display("FAIL abort_cfg_ready: got %b want 1", bus.cfg_ready);
    end
    @(negedge clk);
    total++;
    if ({bus.done, bus.err, bus.addr_valid} !== 3'b000) begin
      bad++;
      $display("FAIL abort_no_done: done/err/valid got %b want 000",
               {bus.done, bus.err, bus.addr_valid});
    end
  endtask

  task automatic test_async_reset(input bit byp);
    $display("desc start=12 size=8 byp=%0d async reset", byp);
    @(negedge clk);
    bus.cfg_valid  = 1'b1;
    bus.startaddr  = ADDR_W'(12);
    bus.datasize   = SIZE_W'(8);
    bus.accbypass  = byp;
    bus.addr_ready = 1'b1;
    @(negedge clk);
    bus.cfg_valid = 1'b0;
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    exp_start_a = 0;
    exp_size_a  = 0;
    exp_byp_a   = 1'b0;
    total++;
    if ({bus.addr, bus.addr_valid, bus.last, bus.busy, bus.done, bus.err} !== '0) begin
      bad++;
      $display("FAIL async_reset: addr=%0d valid=%b last=%b busy=%b done=%b err=%b want all 0",
               bus.addr, bus.addr_valid, bus.last, bus.busy, bus.done, bus.err);
    end
    check_a_regs("async_reset_a_regs");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    total++;
    if ({bus.done, bus.err, bus.busy} !== 3'b000) begin
      bad++;
      $display("FAIL async_reset_release: done/err/busy got %b want 000",
               {bus.done, bus.err, bus.busy});
    end
  endtask

  task automatic test_back_to_back();
    $display("desc start=10 size=2 then start=40 size=3 on last beat");
    @(negedge clk);
    bus.cfg_valid  = 1'b1;
    bus.startaddr  = ADDR_W'(10);
    bus.datasize   = SIZE_W'(2);
    bus.accbypass  = 1'b0;
    bus.addr_ready = 1'b1;
    @(negedge clk);
    bus.cfg_valid = 1'b0;
    exp_start_a = 10;
    exp_size_a  = 2;
    exp_byp_a   = 1'b0;
    @(negedge clk);
    total++;
    if ({bus.addr_valid, bus.addr, bus.last} !== {1'b1, ADDR_W'(11), 1'b1}) begin
      bad++;
      $display("FAIL b2b_last_beat: valid=%b addr=%0d last=%b want 1 11 1",
               bus.addr_valid, bus.addr, bus.last);
    end
`ifdef ACC_SEQ_BACKTOBACK_EN
    bus.cfg_valid = 1'b1;
    bus.startaddr = ADDR_W'(40);
    bus.datasize  = SIZE_W'(3);
    #1;
    total++;
    if (bus.cfg_ready !== 1'b1) begin
      bad++;
      $display("FAIL b2b_cfg_ready: got %b want 1", bus.cfg_ready);
    end
    @(negedge clk);
    bus.cfg_valid = 1'b0;
    exp_start_a = 40;
    exp_size_a  = 3;
    total++;
    if ({bus.done, bus.busy, bus.addr_valid, bus.addr} !== {3'b111, ADDR_W'(40)}) begin
      bad++;
      $display("FAIL b2b_first: done=%b busy=%b valid=%b addr=%0d want 1 1 1 40",
               bus.done, bus.busy, bus.addr_valid, bus.addr);
    end
    check_a_regs("b2b_a_regs");
    repeat (2) @(negedge clk);
    total++;
    if ({bus.addr, bus.last, bus.done} !== {ADDR_W'(42), 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL b2b_tail: addr=%0d last=%b done=%b want 42 1 0", bus.addr, bus.last, bus.done);
    end
    @(negedge clk);
    total++;
    if ({bus.done, bus.addr_valid} !== 2'b10) begin
      bad++;
      $display("FAIL b2b_done: done/valid got %b want 10", {bus.done, bus.addr_valid});
    end
    @(negedge clk);
`else
    #1;
    total++;
    if (bus.cfg_ready !== 1'b0) begin
      bad++;
      $display("FAIL b2b_no_ready: got %b want 0", bus.cfg_ready);
    end
    @(negedge clk);
    total++;
    if ({bus.done, bus.addr_valid, bus.busy} !== 3'b100) begin
      bad++;
      $display("FAIL b2b_done: done/valid/busy got %b want 100",
               {bus.done, bus.addr_valid, bus.busy});
    end
    @(negedge clk);
`endif
  endtask

  task automatic test_random();
    for (int n = 0; n < 24; n++) begin
      run_desc(int'($urandom_range(0, 69)), int'($urandom_range(0, 10)),
               1'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_basic();
    test_backpressure();
    test_edges();
    test_accdone();
    test_async_reset(1'b0);
    test_async_reset(1'b1);
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
